uart_rx_parity: RTL and testbench
=================================

// Module: uart_rx_parity
// PURPOSE
//   Receive-side UART for the 19200-baud serial link: 1 start bit, 8 data bits LSB first,
//   1 parity bit, 1 stop bit (line idles high). Parity = ^data ^ odd.
//   Sits between the FPGA pin and user logic. Delivers each byte with a valid/ack handshake,
//   plus parity, framing and overrun flags.
// PARAMETERS
//   CLK_FREQUENCY  100000000  system clock frequency in Hz
//   BAUD_RATE      19200      serial bit rate; BIT_CYC = CLK_FREQUENCY/BAUD_RATE, HALF_CYC = BIT_CYC/2
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   rx_in        in   1  serial line, asynchronous to clk
//   odd          in   1  parity select; expected parity bit = ^dout ^ odd
//   dout_ack     in   1  consumer takes dout this cycle (only meaningful while dout_valid=1)
//   dout         out  8  received byte, held stable while dout_valid=1
//   dout_valid   out  1  byte available; held until acked
//   parity_err   out  1  parity result for current dout; valid with dout_valid
//   framing_err  out  1  stop bit sampled 0 for current dout; valid with dout_valid
//   overrun      out  1  sticky; a byte was dropped because dout_valid was still 1
//   busy         out  1  high in every state except IDLE
//   state        out  6  one-hot current state, for debug
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - All logic returns immediately to IDLE (state=6'b000001); any frame in progress is discarded.
//   - Outputs clear: dout=0, dout_valid=0, parity_err=0, framing_err=0, overrun=0, busy=0.
//   - Synchronizer flops reset to 1.
// - Input path: rx_in passes through a 2-flop synchronizer (2-cycle latency); the FSM uses the synced value rxs.
// - Timer: width clog2(BIT_CYC); cleared on every state entry; increments otherwise.
// - FSM states, one-hot bit order [5:0] = WAITHI, STOP, PARITY, DATA, START, IDLE:
//   - IDLE:   rxs=0 -> START.
//   - START:  at timer==HALF_CYC-1, sample rxs. 1 -> IDLE (glitch rejected, nothing reported). 0 -> DATA, bit count=0.
//   - DATA:   at timer==BIT_CYC-1, shift rxs into MSB of an 8-bit shift register (so LSB arrives first) and clear the timer.
//             After the 8th sample -> PARITY.
//   - PARITY: at timer==BIT_CYC-1, capture the parity bit -> STOP.
//   - STOP:   at timer==BIT_CYC-1, sample the stop bit and deliver (below).
//             Stop=1 -> IDLE. Stop=0 -> WAITHI.
//   - WAITHI: remain until rxs=1 -> IDLE. A held-low line (break) never restarts reception.
//   - All samples land mid-bit. The +/-2-cycle bit-period difference from our transmitter is within tolerance.
// - Delivery (registered; outputs update the cycle after the stop sample):
//   - dout_valid=0, or dout_ack=1 in the same cycle: load dout, set dout_valid=1, and set
//     parity_err = captured_parity != (^data ^ odd), framing_err = ~stop.
//   - dout_valid=1 and dout_ack=0: drop the new byte; dout and both error flags keep their old values; set overrun=1.
// - Handshake:
//   - dout_ack with dout_valid=1 and no delivery in that cycle: dout_valid=0 next cycle; clear overrun.
//   - dout_ack with dout_valid=0: ignored.
//   - dout_ack in the same cycle as a delivery: old byte consumed, new byte loaded, dout_valid stays 1, overrun cleared.
// - odd is sampled at delivery time; it must be stable for the whole frame.
// TESTING (bench uses CLK_FREQUENCY=1000000, BAUD_RATE=100000 -> BIT_CYC=10; 10-cycle bits unless noted)
//   1. Frame 0xA5, odd=0, parity bit 0, stop 1 -> dout=8'hA5, dout_valid=1, parity_err=0, framing_err=0; hold 5 cycles, then ack -> dout_valid=0.
//   2. Frame 0x01, odd=1, parity bit 1 (wrong; expected 0) -> dout=8'h01, parity_err=1, framing_err=0.
//   3. rx_in low for 3 cycles, then high -> state returns to IDLE, dout_valid stays 0; a following 0x3C frame is received correctly.
//   4. Frame 0x7E with stop=0, line held low 40 cycles -> framing_err=1, state=WAITHI until rx_in rises, then IDLE.
//   5. Frames 0x11 and 0x22 back-to-back, no ack -> dout=8'h11, overrun=1; ack -> dout_valid=0, overrun=0.
//   6. rst_n pulsed low in the middle of DATA -> immediately state=IDLE, busy=0, dout_valid=0; the next 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_parity.sv
// UART receiver: 8 data bits LSB first, one parity bit and one stop bit; the line idles high.
// Each byte is delivered with a valid/ack handshake, together with parity, framing and overrun flags.
module uart_rx_parity #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       odd,
    input  logic       dout_ack,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy,
    output logic [5:0] state
);

    localparam int BIT_CYC  = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int TW       = $clog2(BIT_CYC);

    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYC - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYC - 1);

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        START  = 6'b000010,
        DATA   = 6'b000100,
        PARITY = 6'b001000,
        STOP   = 6'b010000,
        WAITHI = 6'b100000
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            sync1_q, sync2_q;
    logic            rxs;

    logic [7:0]      dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            deliver;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        deliver  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                // Half-bit check rejects short glitches and aligns later samples to mid-bit.
                if (timer_q == HALF_LAST) begin
                    state_d  = rxs ? IDLE : DATA;
                    timer_d  = '0;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    shreg_d  = {rxs, shreg_q[7:1]};
                    timer_d  = '0;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (timer_q == BIT_LAST) begin
                    par_d   = rxs;
                    state_d = STOP;
                    timer_d = '0;
                end
            end
            STOP: begin
                if (timer_q == BIT_LAST) begin
                    deliver = 1'b1;
                    state_d = rxs ? IDLE : WAITHI;
                    timer_d = '0;
                end
            end
            WAITHI: begin
                // A held-low line must rise before a new start bit can be recognized.
                if (rxs) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (deliver && (!valid_q || dout_ack)) begin
            dout_d  = shreg_q;
            valid_d = 1'b1;
            perr_d  = par_q != (^shreg_q ^ odd);
            ferr_d  = ~rxs;
            if (valid_q) ovr_d = 1'b0;
        end else if (deliver) begin
            ovr_d = 1'b1;
        end else if (dout_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != IDLE);
    assign state       = state_q;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity with 10-cycle bits; drives and samples on the falling clock edge.
module tb_uart_rx_parity;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       odd;
    logic       dout_ack;
    logic [7:0] dout;
    logic       dout_valid;
    logic       parity_err;
    logic       framing_err;
    logic       overrun;
    logic       busy;
    logic [5:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [5:0] S_IDLE   = 6'b000001;
    localparam logic [5:0] S_DATA   = 6'b000100;
    localparam logic [5:0] S_WAITHI = 6'b100000;

    uart_rx_parity #(.CLK_FREQUENCY(1000000), .BAUD_RATE(100000)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .odd(odd), .dout_ack(dout_ack),
        .dout(dout), .dout_valid(dout_valid), .parity_err(parity_err),
        .framing_err(framing_err), .overrun(overrun), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic ack;
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_in = 1'b1; odd = 1'b0; dout_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, S_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_flags", {parity_err, framing_err, overrun}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: clean frame, hold, then ack
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("t1_dout", dout, 8'hA5);
        chk("t1_valid", dout_valid, 1);
        chk("t1_perr", parity_err, 0);
        chk("t1_ferr", framing_err, 0);
        repeat (5) @(negedge clk);
        chk("t1_hold", {dout_valid, dout}, {1'b1, 8'hA5});
        ack();
        chk("t1_ack", dout_valid, 0);
        ack();
        chk("t1_ack_idle", dout_valid, 0);

        // 2: wrong parity with odd=1
        odd = 1'b1;
        send_frame(8'h01, 1'b1, 1'b1);
        chk("t2_dout", dout, 8'h01);
        chk("t2_perr", parity_err, 1);
        chk("t2_ferr", framing_err, 0);
        ack();
        odd = 1'b0;

        // 3: 3-cycle glitch, then a good frame
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (15) @(negedge clk);
        chk("t3_state", state, S_IDLE);
        chk("t3_valid", dout_valid, 0);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("t3_frame", {dout_valid, parity_err, framing_err, dout}, {3'b100, 8'h3C});
        ack();

        // 4: framing error, line held low (break)
        send_frame(8'h7E, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("t4_ferr", framing_err, 1);
        chk("t4_dout", {dout_valid, parity_err, dout}, {2'b10, 8'h7E});
        chk("t4_waithi", state, S_WAITHI);
        chk("t4_busy", busy, 1);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_idle", state, S_IDLE);
        ack();

        // 5: back-to-back without ack -> overrun
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        chk("t5_dout", dout, 8'h11);
        chk("t5_ovr", overrun, 1);
        chk("t5_valid", dout_valid, 1);
        ack();
        chk("t5_ack", {dout_valid, overrun}, 2'b00);

        // 6: reset in the middle of DATA with a byte pending
        send_frame(8'hC3, 1'b0, 1'b1);
        chk("t6_pend", {dout_valid, dout}, {1'b1, 8'hC3});
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t6_in_data", state, S_DATA);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state, S_IDLE);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", dout_valid, 0);
        chk("t6_rst_dout", dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("t6_frame", {dout_valid, parity_err, framing_err, overrun, dout}, {4'b1000, 8'h5A});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
